// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register slave.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Command MSB selects write (1) or read (0).
   function automatic int cmd_write_bit(input int data_w);
      return data_w - 1;
   endfunction

   // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rise(input int cpol, input int cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises the SPI pins into clk and produces registered edge pulses
// (latency SYNC_STAGES+1 clk from pin to pulse).
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit CPOL        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ss_n_in,
   input  logic sclk_in,
   input  logic mosi_in,
   output logic ss_fall,
   output logic ss_rise,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic mosi
);

   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES:0]   settle;
   logic ss_d;
   logic sclk_d;
   logic ss_s;
   logic sclk_s;
   logic vld;

   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   // Suppress edges until the chain has flushed its reset value, so a pin that
   // was already active during reset cannot fake a frame start.
   assign vld    = settle[SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= {SYNC_STAGES{CPOL}};
         mosi_sync <= '0;
         settle    <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= CPOL;
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         mosi      <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
         ss_d      <= ss_s;
         sclk_d    <= sclk_s;
         ss_fall   <= vld & ss_d & ~ss_s;
         ss_rise   <= vld & ~ss_d & ss_s;
         sclk_rise <= vld & ~sclk_d & sclk_s;
         sclk_fall <= vld & sclk_d & ~sclk_s;
         mosi      <= mosi_sync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave with command/address framing, burst auto-increment and a register file.
// Define SPI_WR_PROTECT_EN to make reg0 bit0 a write-lock for addresses 1..NUM_REGS-1.
module spi_reg_slave
   import spi_reg_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             spi_ss_n,
   input  logic                             spi_sclk,
   input  logic                             spi_mosi,
   output logic                             spi_miso,
   output logic                             spi_miso_oe,
   output logic [(2**ADDR_W)*DATA_W-1:0]    regs_flat,
   output logic                             wr_strobe,
   output logic [ADDR_W-1:0]                wr_addr,
   output logic [DATA_W-1:0]                wr_data,
   output logic                             busy,
   output logic [1:0]                       dbg_state
);

   localparam int NUM_REGS      = 2**ADDR_W;
   localparam int CMD_WRITE_BIT = cmd_write_bit(DATA_W);
   localparam int CNT_W         = $clog2(DATA_W);
   localparam bit SAMPLE_RISE   = sample_on_rise(CPOL, CPHA);
   localparam bit CPHA1         = (CPHA != 0);

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
   logic sample_edge, shift_edge, last_bit, wr_locked;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-2:0]   shift_in;
   logic [DATA_W-1:0]   shift_out;
   logic [DATA_W-1:0]   word_in;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W-1:0]   next_addr;
   logic                is_write;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .CPOL        (CPOL != 0)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .ss_n_in   (spi_ss_n),
      .sclk_in   (spi_sclk),
      .mosi_in   (spi_mosi),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .mosi      (mosi_s)
   );

   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
   assign word_in     = {shift_in, mosi_s};
   assign last_bit    = (bit_cnt == CNT_W'(DATA_W-1));
   assign next_addr   = addr + 1'b1;
   assign dbg_state   = state;

`ifdef SPI_WR_PROTECT_EN
   assign wr_locked = regs[0][0] && (addr != '0);
`else
   assign wr_locked = 1'b0;
`endif

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         addr        <= '0;
         is_write    <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         busy        <= 1'b0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         // The register lands the clk after the strobe, also outside a frame.
         if (wr_strobe) regs[wr_addr] <= wr_data;

         case (state)
            ST_IDLE: begin
               if (ss_fall) begin
                  state       <= ST_CMD;
                  busy        <= 1'b1;
                  spi_miso_oe <= 1'b1;
                  spi_miso    <= 1'b0;
                  bit_cnt     <= '0;
                  shift_out   <= '0;
               end
            end
            default: begin
               // In CPHA=0 the word load replaces the shift that follows the last sample.
               if (shift_edge && (CPHA1 || bit_cnt != '0)) begin
                  shift_out <= shift_out << 1;
                  spi_miso  <= CPHA1 ? shift_out[DATA_W-1] : shift_out[DATA_W-2];
               end
               if (sample_edge) begin
                  bit_cnt  <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                  shift_in <= word_in[DATA_W-2:0];
                  if (last_bit) begin
                     if (state == ST_CMD) begin
                        state    <= ST_DATA;
                        is_write <= word_in[CMD_WRITE_BIT];
                        addr     <= word_in[ADDR_W-1:0];
                        if (!word_in[CMD_WRITE_BIT]) begin
                           shift_out <= regs[word_in[ADDR_W-1:0]];
                           if (!CPHA1) spi_miso <= regs[word_in[ADDR_W-1:0]][DATA_W-1];
                        end
                     end else begin
                        addr <= next_addr;
                        if (is_write) begin
                           if (!wr_locked) begin
                              wr_strobe <= 1'b1;
                              wr_addr   <= addr;
                              wr_data   <= word_in;
                           end
                        end else begin
                           shift_out <= regs[next_addr];
                           if (!CPHA1) spi_miso <= regs[next_addr][DATA_W-1];
                        end
                     end
                  end
               end
               // A word completing on this same clk has already been committed above.
               if (ss_rise) begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b0;
                  bit_cnt     <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: four 8-bit instances in SPI modes 0..3 plus a 16-bit mode-0 instance.
module tb_spi_reg_slave;

   localparam int H    = 8;   // clk cycles per sclk half period
   localparam int SYNC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              mosi;
   logic [4:0]        ss_n;
   logic [4:0]        sclk;
   logic [4:0]        miso, oe, strobe, busy;
   logic [4:0][1:0]   dbg;
   logic [3:0][127:0] regs8;
   logic [255:0]      regs16;
   logic [4:0][3:0]   waddr;
   logic [3:0][7:0]   wdata8;
   logic [15:0]       wdata16;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   for (genvar g = 0; g < 4; g++) begin : g_mode
      spi_reg_slave #(.DATA_W(8), .ADDR_W(4), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(SYNC)) u_dut (
         .clk(clk), .rst(rst), .spi_ss_n(ss_n[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi),
         .spi_miso(miso[g]), .spi_miso_oe(oe[g]), .regs_flat(regs8[g]), .wr_strobe(strobe[g]),
         .wr_addr(waddr[g]), .wr_data(wdata8[g]), .busy(busy[g]), .dbg_state(dbg[g])
      );
   end

   spi_reg_slave #(.DATA_W(16), .ADDR_W(4), .CPOL(0), .CPHA(0), .SYNC_STAGES(SYNC)) u_dut16 (
      .clk(clk), .rst(rst), .spi_ss_n(ss_n[4]), .spi_sclk(sclk[4]), .spi_mosi(mosi),
      .spi_miso(miso[4]), .spi_miso_oe(oe[4]), .regs_flat(regs16), .wr_strobe(strobe[4]),
      .wr_addr(waddr[4]), .wr_data(wdata16), .busy(busy[4]), .dbg_state(dbg[4])
   );

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vecs[4];

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Master side of one word; nbits LSBs of tx go out MSB first.
   task automatic spi_word(input int sel, input int nbits, input logic [15:0] tx, output logic [15:0] rx);
      logic cpol, cpha;
      cpol = (sel == 2 || sel == 3);
      cpha = (sel == 1 || sel == 3);
      rx = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi = tx[i];
            wait_clks(H);
            sclk[sel] = ~cpol;
            rx[i] = miso[sel];
            wait_clks(H);
            sclk[sel] = cpol;
         end else begin
            wait_clks(H);
            sclk[sel] = ~cpol;
            mosi = tx[i];
            wait_clks(H);
            sclk[sel] = cpol;
            rx[i] = miso[sel];
         end
      end
      wait_clks(H);
   endtask

   task automatic ss_begin(input int sel);
      ss_n[sel] = 1'b0;
      wait_clks(H);
   endtask

   task automatic ss_end(input int sel);
      ss_n[sel] = 1'b1;
      wait_clks(4 * H);
   endtask

   task automatic xfer2(input int sel, input int dw, input logic [15:0] w0, input logic [15:0] w1,
                        output logic [15:0] r1);
      logic [15:0] r0;
      ss_begin(sel);
      spi_word(sel, dw, w0, r0);
      spi_word(sel, dw, w1, r1);
      ss_end(sel);
   endtask

   // Scoreboard: every strobe on the mode-0 instance must match the next expected write.
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst && strobe[0]) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_strobe_unexpected: got addr %h data %h, none expected", waddr[0], wdata8[0]);
         end else begin
            e = exp_q.pop_front();
            if ({waddr[0], wdata8[0]} !== e) begin
               errors++;
               $display("FAIL wr_strobe_payload: got %h expected %h", {waddr[0], wdata8[0]}, e);
            end
         end
      end
   end

   initial begin
      wait_clks(200000);
      $display("FAIL watchdog: simulation did not finish, limit 200000 clk");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rx, rx2;
      int k;

      vecs[0] = '{addr: 4'h0, data: 8'h5A, exp_rd: 8'h5A};
      vecs[1] = '{addr: 4'h9, data: 8'hFF, exp_rd: 8'hFF};
      vecs[2] = '{addr: 4'h5, data: 8'h33, exp_rd: 8'h33};
      vecs[3] = '{addr: 4'hC, data: 8'h81, exp_rd: 8'h81};

      rst  = 1'b1;
      mosi = 1'b0;
      ss_n = 5'b11111;
      sclk = 5'b01100;
      wait_clks(4);
      check("rst_miso", {27'd0, miso}, 32'h0);
      check("rst_oe", {27'd0, oe}, 32'h0);
      check("rst_busy", {27'd0, busy}, 32'h0);
      check("rst_strobe", {27'd0, strobe}, 32'h0);
      check("rst_wr_addr_data", {20'd0, waddr[0], wdata8[0]}, 32'h0);
      check("rst_regs", regs8[0][31:0] | regs8[0][127:96], 32'h0);
      check("rst_state", {30'd0, dbg[0]}, 32'h0);
      rst = 1'b0;
      wait_clks(10);

      // Single write to reg3 with framing visibility
      exp_q.push_back({4'h3, 8'h12});
      ss_begin(0);
      check("busy_at_frame_start", {31'd0, busy[0]}, 32'h1);
      check("oe_at_frame_start", {31'd0, oe[0]}, 32'h1);
      check("state_cmd", {30'd0, dbg[0]}, 32'h1);
      spi_word(0, 8, 16'h83, rx);
      check("state_data", {30'd0, dbg[0]}, 32'h2);
      spi_word(0, 8, 16'h12, rx);
      ss_end(0);
      check("reg3_written", {24'd0, regs8[0][3*8 +: 8]}, 32'h12);
      check("busy_after_frame", {31'd0, busy[0]}, 32'h0);
      xfer2(0, 8, 16'h03, 16'h00, rx);
      check("read_reg3", {16'd0, rx}, 32'h12);

      // Table: write then read back each vector
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({vecs[i].addr, vecs[i].data});
         xfer2(0, 8, {8'h0, 4'h8, vecs[i].addr}, {8'h0, vecs[i].data}, rx);
         xfer2(0, 8, {12'h0, vecs[i].addr}, 16'h00, rx);
         check($sformatf("vec%0d_read", i), {24'd0, rx[7:0]}, {24'd0, vecs[i].exp_rd});
         check($sformatf("vec%0d_reg", i), {24'd0, regs8[0][vecs[i].addr*8 +: 8]}, {24'd0, vecs[i].exp_rd});
      end
      check("reg3_kept", {24'd0, regs8[0][3*8 +: 8]}, 32'h12);

      // Burst write wrapping from reg15 to reg0, then burst read
      exp_q.push_back({4'hF, 8'hA1});
      exp_q.push_back({4'h0, 8'hB2});
      ss_begin(0);
      spi_word(0, 8, 16'h8F, rx);
      spi_word(0, 8, 16'hA1, rx);
      spi_word(0, 8, 16'hB2, rx);
      ss_end(0);
      check("burst_reg15", {24'd0, regs8[0][15*8 +: 8]}, 32'hA1);
      check("burst_reg0", {24'd0, regs8[0][7:0]}, 32'hB2);
      ss_begin(0);
      spi_word(0, 8, 16'h0F, rx);
      spi_word(0, 8, 16'h00, rx);
      spi_word(0, 8, 16'h00, rx2);
      ss_end(0);
      check("burst_read0", {16'd0, rx}, 32'hA1);
      check("burst_read1", {16'd0, rx2}, 32'hB2);

      // Abort after 5 data bits: no write, busy drops quickly
      ss_begin(0);
      spi_word(0, 8, 16'h85, rx);
      spi_word(0, 5, 16'h16, rx);
      ss_n[0] = 1'b1;
      k = 0;
      while (busy[0] && k < 20) begin
         wait_clks(1);
         k++;
      end
      checks++;
      if (busy[0] || k > SYNC + 2) begin
         errors++;
         $display("FAIL abort_busy_latency: busy=%0b after %0d clk, limit %0d clk", busy[0], k, SYNC + 2);
      end
      wait_clks(4 * H);
      check("abort_reg5", {24'd0, regs8[0][5*8 +: 8]}, 32'h33);
      check("abort_oe", {31'd0, oe[0]}, 32'h0);

      // Modes 1..3 and the 16-bit build
      for (int m = 1; m < 4; m++) begin
         xfer2(m, 8, 16'h87, 16'h5A, rx);
         xfer2(m, 8, 16'h07, 16'h00, rx);
         check($sformatf("mode%0d_read", m), {16'd0, rx}, 32'h5A);
         check($sformatf("mode%0d_reg7", m), {24'd0, regs8[m][7*8 +: 8]}, 32'h5A);
      end
      xfer2(4, 16, 16'h8007, 16'hBEEF, rx);
      xfer2(4, 16, 16'h0007, 16'h0000, rx);
      check("w16_read", {16'd0, rx}, 32'hBEEF);
      check("w16_reg7", {16'd0, regs16[7*16 +: 16]}, 32'hBEEF);

      // Reset in the middle of a write; trailing traffic must be ignored
      ss_begin(0);
      spi_word(0, 8, 16'h84, rx);
      spi_word(0, 4, 16'hA, rx);
      rst = 1'b1;
      wait_clks(2);
      rst = 1'b0;
      wait_clks(1);
      check("midrst_regs_lo", regs8[0][63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
      check("midrst_regs_hi", regs8[0][127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
      spi_word(0, 4, 16'h5, rx);
      check("midrst_idle", {29'd0, busy[0], dbg[0]}, 32'h0);
      ss_end(0);
      exp_q.push_back({4'h1, 8'h3C});
      xfer2(0, 8, 16'h81, 16'h3C, rx);
      check("post_rst_reg1", {24'd0, regs8[0][15:8]}, 32'h3C);
      check("post_rst_others", regs8[0][127:16] == 112'h0 ? 32'h0 : 32'h1, 32'h0);

      // Write-lock behaviour on reg0 bit0
      exp_q.push_back({4'h0, 8'h01});
      xfer2(0, 8, 16'h80, 16'h01, rx);
`ifdef SPI_WR_PROTECT_EN
      xfer2(0, 8, 16'h82, 16'h77, rx);
      check("locked_reg2", {24'd0, regs8[0][23:16]}, 32'h00);
      exp_q.push_back({4'h0, 8'h00});
      xfer2(0, 8, 16'h80, 16'h00, rx);
      exp_q.push_back({4'h2, 8'h77});
      xfer2(0, 8, 16'h82, 16'h77, rx);
      check("unlocked_reg2", {24'd0, regs8[0][23:16]}, 32'h77);
`else
      exp_q.push_back({4'h2, 8'h77});
      xfer2(0, 8, 16'h82, 16'h77, rx);
      check("nolock_reg2", {24'd0, regs8[0][23:16]}, 32'h77);
`endif

      wait_clks(10);
      check("writes_outstanding", exp_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
